// File: rtl/mux_scan_seq.sv
// mux_scan_seq: registered W-bit N-to-1 multiplexer with enable, valid flag
// and an auto-scan mode that steps through the channels with programmable dwell.
//
// Ports:
//   clk, reset_n   rising-edge clock, asynchronous active-low reset
//   en             block enable; low forces z=0 / z_valid=0 on the next edge
//   mode           0 = manual select, 1 = auto-scan
//   sel            manual channel select (mode=0)
//   dwell          scan mode: extra cycles each channel is held
//   x              flattened inputs, channel i = x[i*W +: W]
//   z              registered selected data
//   z_valid        z holds a valid channel word
//   cur_ch         channel index that z reflects
//   scan_wrap      one-cycle pulse, raised together with the first cur_ch=0
//                  word that follows a wrap of the scan index
//
// Optional feature (macro MUX_SCAN_MASK_EN): adds scan_mask[N-1:0]; the scan
// advances to the next channel above the current one (with wrap) whose mask
// bit is set. Undefined: every channel is visited in order.
module mux_scan_seq #(
  parameter int unsigned W  = 16,
  parameter int unsigned N  = 16,
  parameter int unsigned SW = $clog2(N),
  parameter int unsigned DW = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [DW-1:0]   dwell,
  input  logic [N*W-1:0]  x,
`ifdef MUX_SCAN_MASK_EN
  input  logic [N-1:0]    scan_mask,
`endif
  output logic [W-1:0]    z,
  output logic            z_valid,
  output logic [SW-1:0]   cur_ch,
  output logic            scan_wrap
);

  localparam logic [SW-1:0] LAST_CH = SW'(N - 1);

  // Unflattened view of the channel inputs
  logic [W-1:0] ch_word [N];
  for (genvar i = 0; i < int'(N); i++) begin : g_ch
    assign ch_word[i] = x[i*W +: W];
  end

  logic [SW-1:0] idx_q, idx_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          wrap_pend_q, wrap_pend_d;
  logic [W-1:0]  z_d;
  logic          z_valid_d;
  logic [SW-1:0] cur_ch_d;
  logic          scan_wrap_d;

  logic          sel_ok;
  logic [SW-1:0] nxt_idx;
  logic          nxt_wrap;
  logic          scan_live;
  logic          advance;

  assign sel_ok = (32'(sel) < N);

`ifdef MUX_SCAN_MASK_EN
  logic [SW:0] cand;
  logic        cand_wrap;
  logic        found;

  // One-cycle upward search (with wrap) for the next enabled channel
  always_comb begin
    nxt_idx   = idx_q;
    nxt_wrap  = 1'b0;
    found     = 1'b0;
    cand      = '0;
    cand_wrap = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand      = {1'b0, idx_q} + (SW+1)'(k);
      cand_wrap = (cand >= (SW+1)'(N));
      if (cand_wrap) begin
        cand = cand - (SW+1)'(N);
      end
      if (!found && scan_mask[cand[SW-1:0]]) begin
        found    = 1'b1;
        nxt_idx  = cand[SW-1:0];
        nxt_wrap = cand_wrap;
      end
    end
  end

  // A disabled current channel is left immediately
  assign scan_live = |scan_mask;
  assign advance   = (cnt_q >= dwell) || !scan_mask[idx_q];
`else
  // Plain sequential scan
  always_comb begin
    nxt_wrap = (idx_q == LAST_CH);
    nxt_idx  = nxt_wrap ? '0 : idx_q + SW'(1);
  end

  assign scan_live = 1'b1;
  assign advance   = (cnt_q >= dwell);
`endif

  // Next-state and output selection
  always_comb begin
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    wrap_pend_d = wrap_pend_q;
    z_d         = z;
    z_valid_d   = z_valid;
    cur_ch_d    = cur_ch;
    scan_wrap_d = 1'b0;

    if (!en) begin
      z_d       = '0;
      z_valid_d = 1'b0;
    end else if (!mode) begin
      // Manual: dwell count held clear so a switch to scan starts fresh
      cnt_d       = '0;
      wrap_pend_d = 1'b0;
      if (sel_ok) begin
        z_d       = ch_word[sel];
        z_valid_d = 1'b1;
        cur_ch_d  = sel;
        idx_d     = sel;
      end else begin
        z_d       = '0;
        z_valid_d = 1'b0;
      end
    end else if (!scan_live) begin
      z_d       = '0;
      z_valid_d = 1'b0;
    end else begin
      z_d         = ch_word[idx_q];
      z_valid_d   = 1'b1;
      cur_ch_d    = idx_q;
      // Pulse lines up with the first post-wrap word on z/cur_ch
      scan_wrap_d = wrap_pend_q;
      wrap_pend_d = 1'b0;
      if (advance) begin
        idx_d       = nxt_idx;
        cnt_d       = '0;
        wrap_pend_d = nxt_wrap;
      end else begin
        cnt_d = cnt_q + DW'(1);
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q       <= '0;
      cnt_q       <= '0;
      wrap_pend_q <= 1'b0;
      z           <= '0;
      z_valid     <= 1'b0;
      cur_ch      <= '0;
      scan_wrap   <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      wrap_pend_q <= wrap_pend_d;
      z           <= z_d;
      z_valid     <= z_valid_d;
      cur_ch      <= cur_ch_d;
      scan_wrap   <= scan_wrap_d;
    end
  end

endmodule

// File: tb/tb_mux_scan_seq.sv
// tb_mux_scan_seq: directed walk through the documented scenarios followed by
// randomized stimulus, all checked against a cycle-level reference model.
module tb_mux_scan_seq;

  localparam int unsigned W   = 16;
  localparam int unsigned N   = 16;
  localparam int unsigned SW  = 4;
  localparam int unsigned DW  = 8;
  localparam int unsigned N12 = 12;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            en = 1'b0;
  logic            mode = 1'b0;
  logic [SW-1:0]   sel = '0;
  logic [DW-1:0]   dwell = '0;
  logic [N*W-1:0]  x = '0;
  logic [N-1:0]    mask = '1;
  logic [W-1:0]    z;
  logic            z_valid;
  logic [SW-1:0]   cur_ch;
  logic            scan_wrap;

  logic [SW-1:0]   sel12 = '0;
  logic [N12*W-1:0] x12 = '0;
  logic [N12-1:0]  mask12 = '1;
  logic [W-1:0]    z12;
  logic            z_valid12;
  logic [SW-1:0]   cur_ch12;
  logic            scan_wrap12;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int         m_ch, m_held;
  bit         m_wr;
  logic [W-1:0] e_z;
  bit         e_v, e_w;
  int         e_ch;

  always #5 clk = ~clk;

  mux_scan_seq #(.W(W), .N(N), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .sel(sel),
    .dwell(dwell), .x(x),
`ifdef MUX_SCAN_MASK_EN
    .scan_mask(mask),
`endif
    .z(z), .z_valid(z_valid), .cur_ch(cur_ch), .scan_wrap(scan_wrap)
  );

  mux_scan_seq #(.W(W), .N(N12), .DW(DW)) dut12 (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(1'b0), .sel(sel12),
    .dwell(dwell), .x(x12),
`ifdef MUX_SCAN_MASK_EN
    .scan_mask(mask12),
`endif
    .z(z12), .z_valid(z_valid12), .cur_ch(cur_ch12), .scan_wrap(scan_wrap12)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [W-1:0] chan(input int i);
    return x[i*W +: W];
  endfunction

  task automatic model_reset();
    m_ch = 0; m_held = 0; m_wr = 0;
    e_z = '0; e_v = 0; e_w = 0; e_ch = 0;
  endtask

  // One clock: predict from the applied inputs, then compare away from the edge
  task automatic step();
    int k;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else if (!en) begin
      e_z = '0; e_v = 0; e_w = 0;
    end else if (!mode) begin
      e_w = 0; m_held = 0; m_wr = 0;
      if (32'(sel) < N) begin
        m_ch = int'(sel); e_ch = m_ch; e_z = chan(m_ch); e_v = 1;
      end else begin
        e_z = '0; e_v = 0;
      end
    end else if (mask == '0) begin
      e_z = '0; e_v = 0; e_w = 0;
    end else begin
      e_ch = m_ch; e_z = chan(m_ch); e_v = 1; e_w = m_wr; m_wr = 0;
      m_held++;
      // Channel has been shown dwell+1 times (or is masked off): move on
      if (m_held > int'(dwell) || !mask[m_ch]) begin
        k = 1;
        while (!mask[(m_ch + k) % int'(N)]) k++;
        m_wr   = (m_ch + k >= int'(N));
        m_ch   = (m_ch + k) % int'(N);
        m_held = 0;
      end
    end
    @(negedge clk);
    check("z", 32'(z), 32'(e_z));
    check("z_valid", 32'(z_valid), 32'(e_v));
    check("cur_ch", 32'(cur_ch), 32'(e_ch));
    check("scan_wrap", 32'(scan_wrap), 32'(e_w));
  endtask

  initial begin
    int tp_sel [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 15};
    for (int i = 0; i <= 8; i++) x[i*W +: W] = W'(1 << i);
    x[15*W +: W] = W'(1000);
    for (int i = 0; i < int'(N12); i++) x12[i*W +: W] = W'($urandom);
    x12[11*W +: W] = 16'habcd;
    model_reset();

    // Reset, then manual walk
    reset_n = 1'b0;
    step(); step();
    check("rst_z", 32'(z), 32'd0);
    check("rst_cur_ch", 32'(cur_ch), 32'd0);
    reset_n = 1'b1;
    en = 1'b1; mode = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sel = SW'(tp_sel[i]);
      step();
      check("tp_manual_z", 32'(z), (tp_sel[i] == 15) ? 32'd1000 : 32'(1 << tp_sel[i]));
    end

    // Enable gating
    sel = 4'd3; step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("tp_gate_z", 32'(z), 32'd0);
    check("tp_gate_cur_ch", 32'(cur_ch), 32'd3);
    en = 1'b1; step();
    check("tp_ungate_z", 32'(z), 32'd8);

    // Scan, dwell=0, full lap plus the wrap back to channel 0
    sel = '0; step();
    mode = 1'b1; dwell = '0;
    for (int i = 0; i < 16; i++) begin
      step();
      check("tp_scan_nowrap", 32'(scan_wrap), 32'd0);
    end
    step();
    check("tp_scan_wrap", 32'(scan_wrap), 32'd1);
    check("tp_scan_ch0", 32'(cur_ch), 32'd0);

    // Scan, dwell=2, async reset mid-hold
    mode = 1'b0; sel = '0; step();
    mode = 1'b1; dwell = 8'd2;
    for (int i = 0; i < 4; i++) step();
    check("tp_dwell_ch", 32'(cur_ch), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("tp_async_z", 32'(z), 32'd0);
    check("tp_async_valid", 32'(z_valid), 32'd0);
    check("tp_async_cur_ch", 32'(cur_ch), 32'd0);
    model_reset();
    @(posedge clk); @(negedge clk);
    reset_n = 1'b1;
    step();
    check("tp_restart_z", 32'(z), 32'd1);
    for (int i = 0; i < 5; i++) step();

    // Out-of-range select on the 12-channel instance
    sel12 = 4'd13; step();
    check("n12_oor_z", 32'(z12), 32'd0);
    check("n12_oor_valid", 32'(z_valid12), 32'd0);
    sel12 = 4'd11; step();
    check("n12_z", 32'(z12), 32'habcd);
    check("n12_valid", 32'(z_valid12), 32'd1);
    check("n12_cur_ch", 32'(cur_ch12), 32'd11);

`ifdef MUX_SCAN_MASK_EN
    begin : mask_tp
      int exp_ch [7] = '{0, 2, 15, 0, 2, 15, 0};
      int exp_w  [7] = '{0, 0, 0, 1, 0, 0, 1};
      mode = 1'b0; sel = '0; step();
      mask = 16'h8005; mode = 1'b1; dwell = '0;
      for (int i = 0; i < 7; i++) begin
        step();
        check("mask_ch", 32'(cur_ch), 32'(exp_ch[i]));
        check("mask_wrap", 32'(scan_wrap), 32'(exp_w[i]));
      end
      mask = '0; step();
      check("mask_zero_valid", 32'(z_valid), 32'd0);
      mask = '1;
    end
`endif

    // Randomized stimulus
    for (int c = 0; c < 1500; c++) begin
      en = ($urandom_range(0, 99) < 90);
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      sel = SW'($urandom);
      if ($urandom_range(0, 15) == 0) dwell = DW'($urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) x[$urandom_range(0, N-1)*W +: W] = W'($urandom);
`ifdef MUX_SCAN_MASK_EN
      if ($urandom_range(0, 49) == 0)
        mask = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
`endif
      reset_n = ($urandom_range(0, 299) != 0);
      step();
      reset_n = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
